// File: rtl/tick_generator.sv
// Clock-enable generator pacing the accumulator processor: full speed, divided,
// debounced single-step and halt modes, plus a wrapping count of issued ticks.
module tick_generator #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TCNT_W     = 16,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  div_value,
  input  logic              step_btn,
  input  logic              clr_count,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_count,
  output logic              step_level
);

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HALT = 2'b11
  } mode_e;

  localparam int unsigned      DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  div_last;
  logic              tick_d;
  logic              sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic              level_d;
  logic              step_rise;

  // Debounce runs in every mode; only a rise seen while in step mode ticks.
  always_comb begin
    deb_d     = '0;
    level_d   = step_level;
    step_rise = 1'b0;
    if (sync2_q != step_level) begin
      if (deb_q >= DEB_LAST) begin
        level_d   = sync2_q;
        step_rise = sync2_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  always_comb begin
    mode_d   = mode_e'(mode);
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    div_last = (div_value == '0) ? '0 : div_value - 1'b1;
    if (mode != mode_q) begin
      // A mode change swallows any pending divide or step tick.
      cnt_d = '0;
    end else begin
      case (mode_q)
        MODE_FULL: tick_d = 1'b1;
        MODE_DIV: begin
          if (cnt_q >= div_last) begin
            tick_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_STEP: tick_d = step_rise;
        MODE_HALT: tick_d = 1'b0;
        default:   tick_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_HALT;
      cnt_q      <= '0;
      tick       <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= '0;
      step_level <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      tick       <= tick_d;
      sync1_q    <= step_btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      step_level <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_count <= '0;
    end else if (clr_count) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= tick_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: a cycle model pushes expected outputs
// into a scoreboard queue as stimulus is applied; they are popped after each edge.
module tb_tick_generator;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TCNT_W = 4;
  localparam int unsigned DEB    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  div_value;
  logic              step_btn;
  logic              clr_count;
  logic              tick;
  logic [TCNT_W-1:0] tick_count;
  logic              step_level;

  tick_generator #(
    .CNT_W      (CNT_W),
    .TCNT_W     (TCNT_W),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .div_value  (div_value),
    .step_btn   (step_btn),
    .clr_count  (clr_count),
    .tick       (tick),
    .tick_count (tick_count),
    .step_level (step_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tick;
    int tcnt;
    int lvl;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   obs_tick;
  int   tick_sum;

  // Reference model state
  int m_mode_q, m_cnt, m_tick, m_tcnt, m_s1, m_s2, m_lvl, m_deb;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_eval();
    int  n_tick, n_cnt, n_lvl, n_deb, n_tcnt, d_eff;
    bit  rise;
    if (!rst_n) begin
      m_mode_q = 3; m_cnt = 0; m_tick = 0; m_tcnt = 0;
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_deb = 0;
      return;
    end
    rise  = 0;
    n_lvl = m_lvl;
    n_deb = 0;
    if (m_s2 != m_lvl) begin
      if (m_deb + 1 >= DEB) begin
        n_lvl = m_s2;
        rise  = (m_s2 == 1);
      end else begin
        n_deb = m_deb + 1;
      end
    end
    n_tcnt = clr_count ? 0 : (m_tcnt + m_tick) % (1 << TCNT_W);
    n_tick = 0;
    n_cnt  = m_cnt;
    if (int'(mode) != m_mode_q) begin
      n_cnt = 0;
    end else if (m_mode_q == 0) begin
      n_tick = 1;
    end else if (m_mode_q == 1) begin
      d_eff = (div_value == 0) ? 1 : int'(div_value);
      if (m_cnt + 1 >= d_eff) begin
        n_tick = 1;
        n_cnt  = 0;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end else if (m_mode_q == 2) begin
      n_tick = rise ? 1 : 0;
    end
    m_mode_q = int'(mode);
    m_cnt    = n_cnt;
    m_tick   = n_tick;
    m_tcnt   = n_tcnt;
    m_s2     = m_s1;
    m_s1     = int'(step_btn);
    m_lvl    = n_lvl;
    m_deb    = n_deb;
  endtask

  // One clock: model the edge, queue expectations, then compare after the edge.
  task automatic step();
    exp_t e;
    model_eval();
    e.tick = m_tick;
    e.tcnt = m_tcnt;
    e.lvl  = m_lvl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check("tick", int'(tick), e.tick);
    check("tick_count", int'(tick_count), e.tcnt);
    check("step_level", int'(step_level), e.lvl);
    obs_tick = int'(tick);
  endtask

  task automatic run(input int n);
    tick_sum = 0;
    for (int i = 0; i < n; i++) begin
      step();
      tick_sum += obs_tick;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int saved;
    rst_n = 1'b0; mode = 2'b00; div_value = '0; step_btn = 1'b0; clr_count = 1'b0;
    m_mode_q = 3; m_cnt = 0; m_tick = 0; m_tcnt = 0;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_deb = 0;
    #2;
    run(3);
    check("rst_tick", int'(tick), 0);
    check("rst_count", int'(tick_count), 0);

    // Full speed: first tick on the 2nd edge after release, then wrap
    rst_n = 1'b1;
    step();
    check("fs_first_edge", obs_tick, 0);
    step();
    check("fs_second_edge", obs_tick, 1);
    run(20);
    check("fs_wrap", int'(tick_count), 4);

    // Reset mid-operation
    rst_n = 1'b0;
    step();
    check("midrst_tick", int'(tick), 0);
    rst_n = 1'b1;
    run(4);

    // clr_count beats increment
    clr_count = 1'b1;
    step();
    check("clr_hit", int'(tick_count), 0);
    clr_count = 1'b0;
    step();
    check("clr_next", int'(tick_count), 1);

    // Divided mode
    mode = 2'b01; div_value = 8'd5;
    step();
    run(30);
    check("div5_ticks", tick_sum, 6);
    div_value = 8'd0;
    run(5);
    check("div0_ticks", tick_sum, 5);
    div_value = 8'd1;
    run(5);
    check("div1_ticks", tick_sum, 5);

    // Divide shrink mid-count
    div_value = 8'd200;
    run(100);
    check("div200_ticks", tick_sum, 0);
    div_value = 8'd10;
    step();
    check("shrink_tick", obs_tick, 1);
    run(30);
    check("div10_ticks", tick_sum, 3);

    // Halt on the cycle a tick would occur
    div_value = 8'd3;
    guard = 0;
    while (m_cnt != 2 && guard < 10) begin
      step();
      guard++;
    end
    check("halt_align", (m_cnt == 2) ? 1 : 0, 1);
    saved = m_tcnt;
    mode = 2'b11;
    step();
    check("halt_drop", obs_tick, 0);
    run(10);
    check("halt_ticks", tick_sum, 0);
    check("halt_count", int'(tick_count), saved);

    // Resume divide: first tick 3 edges after the mode-change edge
    mode = 2'b01;
    step();
    run(2);
    check("resume_early", tick_sum, 0);
    step();
    check("resume_tick", obs_tick, 1);

    // Press completed in halt gives no deferred tick in step mode
    mode = 2'b11;
    step();
    step_btn = 1'b1;
    run(12);
    mode = 2'b10;
    step();
    run(10);
    check("no_defer", tick_sum, 0);
    step_btn = 1'b0;
    run(10);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;

    // Bouncing press then stable high: one tick
    tick_sum = 0;
    for (int i = 0; i < 12; i++) begin
      step_btn = ((i / 2) % 2 == 0);
      step();
      saved = obs_tick;
      check("bounce_quiet", saved, 0);
    end
    step_btn = 1'b1;
    run(20);
    check("press1_ticks", tick_sum, 1);
    step_btn = 1'b0;
    run(10);
    check("release_ticks", tick_sum, 0);
    step_btn = 1'b1;
    run(20);
    check("press2_ticks", tick_sum, 1);
    check("step_count", int'(tick_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
